bin2sevenseg_digits: RTL and testbench

- Upstream feeder for the N-digit seven-segment multiplexer.
- Converts an unsigned binary value to decimal with a sequential double-dabble (shift-add-3) engine.
- Encodes each decimal digit into an active-low segment pattern and holds the patterns in an output register array.
- Also generates the periodic one-cycle refresh tick that drives the multiplexer's digit-advance enable.

---
 rtl/bin2sevenseg_digits_if.sv | 22 ++
 rtl/bin2sevenseg_digits.sv | 143 ++++++++++++++
 tb/tb_bin2sevenseg_digits.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/bin2sevenseg_digits_if.sv
// Conversion request / result bundle between a controller and bin2sevenseg_digits.
interface bin2sevenseg_digits_if #(
   parameter int N = 2,
   parameter int W = 7
);
   logic         start;
   logic [W-1:0] value;
   logic         busy;
   logic         done;
   logic         overflow;
   logic [6:0]   digit_values [N];

   modport master (
      output start, value,
      input  busy, done, overflow, digit_values
   );

   modport slave (
      input  start, value,
      output busy, done, overflow, digit_values
   );
endinterface

// File: rtl/bin2sevenseg_digits.sv
// Binary -> BCD (sequential double-dabble) -> active-low seven-segment digits, plus refresh tick.
// Optional macro LZB_EN: blank leading zero digits (units digit always shown).
module bin2sevenseg_digits #(
   parameter int N        = 2,
   parameter int W        = 7,
   parameter int TICK_DIV = 50000
) (
   input  logic                  clk,
   input  logic                  reset,
   bin2sevenseg_digits_if.slave  bus,
   output logic                  en_tick
);
   localparam int BW   = 4 * N;
   localparam int CW   = (W > BW + 1) ? W : BW + 1;
   localparam int CNTW = $clog2(W + 1);
   localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   // 10^N always fits in 4N+1 bits, so comparing at CW bits is exact for any W.
   function automatic logic [CW-1:0] pow10_f();
      logic [CW-1:0] p;
      p = CW'(1);
      for (int unsigned i = 0; i < N; i++) p = p * CW'(10);
      return p;
   endfunction

   localparam logic [CW-1:0] LIMIT = pow10_f();

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    return 7'h40;
         4'd1:    return 7'h79;
         4'd2:    return 7'h24;
         4'd3:    return 7'h30;
         4'd4:    return 7'h19;
         4'd5:    return 7'h12;
         4'd6:    return 7'h02;
         4'd7:    return 7'h78;
         4'd8:    return 7'h00;
         4'd9:    return 7'h10;
         default: return SEG_BLANK;
      endcase
   endfunction

   typedef enum logic [1:0] {IDLE, CONV, ENCODE} state_t;

   state_t          state;
   logic [W-1:0]    bin;
   logic [BW-1:0]   bcd;
   logic [BW-1:0]   bcd_adj;
   logic [CNTW-1:0] cnt;
   logic            ovf_pend;
   logic [6:0]      enc [N];
   logic [TW-1:0]   tcnt;

   always_comb begin
      bcd_adj = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         else                       bcd_adj[4*i +: 4] = bcd[4*i +: 4];
      end
   end

`ifdef LZB_EN
   // lz[i]: every digit at index >= i is zero
   logic [N:0] lz;

   always_comb begin
      lz[N] = 1'b1;
      for (int unsigned k = 0; k < N; k++) begin
         lz[N-1-k] = lz[N-k] && (bcd[4*(N-1-k) +: 4] == 4'd0);
      end
      for (int unsigned i = 0; i < N; i++) begin
         if (ovf_pend)              enc[i] = SEG_DASH;
         else if (i != 0 && lz[i])  enc[i] = SEG_BLANK;
         else                       enc[i] = seg7(bcd[4*i +: 4]);
      end
   end
`else
   always_comb begin
      for (int unsigned i = 0; i < N; i++) begin
         if (ovf_pend) enc[i] = SEG_DASH;
         else          enc[i] = seg7(bcd[4*i +: 4]);
      end
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.overflow <= 1'b0;
         bin          <= '0;
         bcd          <= '0;
         cnt          <= '0;
         ovf_pend     <= 1'b0;
         for (int unsigned i = 0; i < N; i++) bus.digit_values[i] <= SEG_BLANK;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  bin      <= bus.value;
                  bcd      <= '0;
                  cnt      <= CNTW'(W);
                  ovf_pend <= (CW'(bus.value) >= LIMIT);
                  bus.busy <= 1'b1;
                  state    <= CONV;
               end
            end
            CONV: begin
               // adjust-then-shift of the combined {bcd, bin} register
               bcd <= BW'({bcd_adj, bin[W-1]});
               bin <= bin << 1;
               cnt <= cnt - 1'b1;
               if (cnt == CNTW'(1)) state <= ENCODE;
            end
            ENCODE: begin
               for (int unsigned i = 0; i < N; i++) bus.digit_values[i] <= enc[i];
               bus.overflow <= ovf_pend;
               bus.done     <= 1'b1;
               bus.busy     <= 1'b0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tcnt    <= '0;
         en_tick <= 1'b0;
      end else begin
         en_tick <= (tcnt == TW'(TICK_DIV - 1));
         if (tcnt == TW'(TICK_DIV - 1)) tcnt <= '0;
         else                           tcnt <= tcnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_bin2sevenseg_digits.sv
// Scoreboard bench for bin2sevenseg_digits (N=2, W=7); second instance exercises TICK_DIV=1.
module tb_bin2sevenseg_digits;
   localparam int N  = 2;
   localparam int W  = 7;
   localparam int TD = 4;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   logic en_tick, en_tick1;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   bin2sevenseg_digits_if #(.N(N), .W(W)) bus ();
   bin2sevenseg_digits_if #(.N(N), .W(W)) bus1 ();

   bin2sevenseg_digits #(.N(N), .W(W), .TICK_DIV(TD)) dut (
      .clk(clk), .reset(reset), .bus(bus), .en_tick(en_tick)
   );

   bin2sevenseg_digits #(.N(N), .W(W), .TICK_DIV(1)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1), .en_tick(en_tick1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   typedef struct {
      logic [6:0] d0;
      logic [6:0] d1;
      logic       ovf;
      int         scyc;
   } exp_t;

   exp_t sb[$];

   function automatic logic [6:0] seg(input int d);
      case (d)
         0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
         4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
         8: return 7'h00;  9: return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   function automatic exp_t model(input int v, input int s);
      exp_t e;
      e.scyc = s;
      if (v >= 100) begin
         e.d0 = 7'h3F; e.d1 = 7'h3F; e.ovf = 1'b1;
      end else begin
         e.d0 = seg(v % 10); e.d1 = seg(v / 10); e.ovf = 1'b0;
`ifdef LZB_EN
         if (v < 10) e.d1 = 7'h7F;
`endif
      end
      return e;
   endfunction

   // Called on a falling edge; the start is accepted at the next rising edge.
   task automatic drive_start(input int v);
      bus.start = 1'b1;
      bus.value = W'(v);
      sb.push_back(model(v, cyc));
   endtask

   // Waits for done (bounded); optionally injects a second start inj_at cycles in.
   task automatic wait_done(input int inj_at, input int inj_val,
                            output bit got, output int at_cyc, output int busy_n);
      got = 1'b0; at_cyc = -1; busy_n = 0;
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clk);
         if (i == 0) begin
            bus.start = 1'b0;
            bus.value = ~bus.value;
         end
         if (i == inj_at) begin bus.start = 1'b1; bus.value = W'(inj_val); end
         if (i == inj_at + 1) bus.start = 1'b0;
         if (bus.busy === 1'b1) busy_n++;
         if (bus.done === 1'b1) begin got = 1'b1; at_cyc = cyc; end
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
      total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", bus.overflow); end
      total++; if (en_tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b want=0", en_tick); end
      total++; if (en_tick1 !== 1'b0) begin bad++; $display("FAIL reset_tick1 got=%b want=0", en_tick1); end
      for (int i = 0; i < N; i++) begin
         total++;
         if (bus.digit_values[i] !== 7'h7F) begin
            bad++; $display("FAIL reset_digit%0d got=%h want=7f", i, bus.digit_values[i]);
         end
      end
   endtask

   task automatic test_tick();
      reset = 1'b1;
      for (int k = 1; k <= 13; k++) begin
         @(negedge clk);
         total++;
         if (en_tick !== ((k % TD) == 0)) begin
            bad++; $display("FAIL tick4_cycle%0d got=%b want=%b", k, en_tick, (k % TD) == 0);
         end
         total++;
         if (en_tick1 !== 1'b1) begin bad++; $display("FAIL tick1_cycle%0d got=%b want=1", k, en_tick1); end
      end
   endtask

   task automatic test_convert(input int v);
      bit   got;
      int   at, bn;
      exp_t e;
      @(negedge clk);
      drive_start(v);
      wait_done(-5, 0, got, at, bn);
      total++;
      if (!got || sb.size() == 0) begin
         bad++; $display("FAIL conv%0d_done got=%b want=1", v, got);
         sb.delete();
         return;
      end
      e = sb.pop_front();
      total++; if (at - e.scyc !== 9) begin bad++; $display("FAIL conv%0d_latency got=%0d want=9", v, at - e.scyc); end
      total++; if (bn !== 8) begin bad++; $display("FAIL conv%0d_busy_cycles got=%0d want=8", v, bn); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL conv%0d_busy_at_done got=%b want=0", v, bus.busy); end
      total++; if (bus.digit_values[0] !== e.d0) begin bad++; $display("FAIL conv%0d_d0 got=%h want=%h", v, bus.digit_values[0], e.d0); end
      total++; if (bus.digit_values[1] !== e.d1) begin bad++; $display("FAIL conv%0d_d1 got=%h want=%h", v, bus.digit_values[1], e.d1); end
      total++; if (bus.overflow !== e.ovf) begin bad++; $display("FAIL conv%0d_ovf got=%b want=%b", v, bus.overflow, e.ovf); end
      @(negedge clk);
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL conv%0d_done_width got=%b want=0", v, bus.done); end
   endtask

   task automatic test_digits();
      int vals[6] = '{42, 5, 0, 100, 99, 127};
      foreach (vals[i]) test_convert(vals[i]);
   endtask

   task automatic test_start_busy();
      bit   got;
      int   at, bn, extra;
      exp_t e;
      @(negedge clk);
      drive_start(42);
      wait_done(2, 77, got, at, bn);
      total++;
      if (!got) begin bad++; $display("FAIL busy_start_done got=0 want=1"); sb.delete(); return; end
      e = sb.pop_front();
      total++; if (bus.digit_values[0] !== e.d0) begin bad++; $display("FAIL busy_start_d0 got=%h want=%h", bus.digit_values[0], e.d0); end
      total++; if (bus.digit_values[1] !== e.d1) begin bad++; $display("FAIL busy_start_d1 got=%h want=%h", bus.digit_values[1], e.d1); end
      extra = 0;
      repeat (14) begin
         @(negedge clk);
         if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
      end
      total++; if (extra !== 0) begin bad++; $display("FAIL busy_start_queued got=%0d want=0", extra); end
   endtask

   task automatic test_back_to_back();
      bit   got;
      int   at, bn;
      exp_t e;
      @(negedge clk);
      drive_start(42);
      wait_done(-5, 0, got, at, bn);
      total++;
      if (!got) begin bad++; $display("FAIL b2b_first_done got=0 want=1"); sb.delete(); return; end
      void'(sb.pop_front());
      drive_start(77);
      wait_done(-5, 0, got, at, bn);
      total++;
      if (!got) begin bad++; $display("FAIL b2b_second_done got=0 want=1"); sb.delete(); return; end
      e = sb.pop_front();
      total++; if (at - e.scyc !== 9) begin bad++; $display("FAIL b2b_latency got=%0d want=9", at - e.scyc); end
      total++; if (bus.digit_values[0] !== e.d0) begin bad++; $display("FAIL b2b_d0 got=%h want=%h", bus.digit_values[0], e.d0); end
      total++; if (bus.digit_values[1] !== e.d1) begin bad++; $display("FAIL b2b_d1 got=%h want=%h", bus.digit_values[1], e.d1); end
   endtask

   task automatic test_reset_mid();
      int dn;
      @(negedge clk);
      drive_start(42);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", bus.busy); end
      total++; if (bus.digit_values[0] !== 7'h7F) begin bad++; $display("FAIL rstmid_d0 got=%h want=7f", bus.digit_values[0]); end
      total++; if (bus.digit_values[1] !== 7'h7F) begin bad++; $display("FAIL rstmid_d1 got=%h want=7f", bus.digit_values[1]); end
      sb.delete();
      dn = 0;
      repeat (3) begin @(negedge clk); if (bus.done === 1'b1) dn++; end
      reset = 1'b1;
      repeat (10) begin @(negedge clk); if (bus.done === 1'b1) dn++; end
      total++; if (dn !== 0) begin bad++; $display("FAIL rstmid_done_pulses got=%0d want=0", dn); end
      total++; if (bus.digit_values[0] !== 7'h7F) begin bad++; $display("FAIL rstmid_hold_d0 got=%h want=7f", bus.digit_values[0]); end
      test_convert(42);
   endtask

   initial begin
      bus.start  = 1'b0;
      bus.value  = '0;
      bus1.start = 1'b0;
      bus1.value = '0;
      test_reset();
      test_tick();
      test_digits();
      test_start_busy();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
